sn_api_sweep_sched: RTL and testbench
=====================================

// Module: sn_api_sweep_sched
// PURPOSE
//  Transmit-phase scheduler for the shared Axon Protocol Interface (API) bus.
//  At each transmit phase it snapshots which input/hidden neurons have a pending spike.
//  It then grants those neurons one per cycle, so each granted neuron drives api_bus alone.
//  When the snapshot has drained it signals the network controller.
//  Sits between the neuron array (pending/granted), the network controller (transmit/done) and the IO manager (status).
// PARAMETERS
//  P_NUM_NEURONS   100  total neurons, including inputs and outputs
//  P_NUM_INPUTS    45   number of input neurons (indices 1..P_NUM_INPUTS)
//  P_NUM_OUTPUTS   3    number of output neurons (these never request the bus)
//  P_RR_EN         0    0: fixed priority, lowest index first; 1: rotating start pointer across phases
//  L_NUM_REQ       P_NUM_NEURONS-P_NUM_OUTPUTS   (localparam) number of requesters
//  L_CNT_BW        $clog2(L_NUM_REQ+1)           (localparam) width of the grant counter
// PORTS
//  clk              in   1          clock; all state changes on rising edge
//  rst              in   1          reset; asynchronous, active-low (0 = reset)
//  nc_transmit      in   1          transmit-phase start pulse from the network controller
//  api_pending      in   L_NUM_REQ  [L_NUM_REQ:1] per-neuron spike-pending request
//  err_clr          in   1          clears api_err_overlap
//  api_granted      out  L_NUM_REQ  [L_NUM_REQ:1] one-hot grant; all zeros when nothing is granted
//  api_vld          out  1          api_bus valid; equals |api_granted
//  api_nc_done      out  1          one-cycle pulse: transmit phase complete
//  api_grant_cnt    out  L_CNT_BW   number of grants issued in the current or last phase
//  api_err_overlap  out  1          sticky flag: nc_transmit seen while not IDLE
// BEHAVIOUR
//  Reset values (rst=0, asynchronous): req_q=0, ptr=1, state=IDLE.
//   All outputs reset to 0: api_granted, api_vld, api_nc_done, api_grant_cnt, api_err_overlap.
//  FSM states: IDLE, GRANT, DONE.
//   IDLE: on nc_transmit=1:
//    - req_q <= api_pending; api_grant_cnt <= 0.
//    - Go to GRANT if api_pending!=0, otherwise go to DONE.
//   GRANT:
//    - api_granted = one-hot of the selected bit of req_q (combinational from registered req_q and ptr).
//    - Clear the selected bit in req_q; api_grant_cnt += 1.
//    - If req_q has exactly one bit set, go to DONE; otherwise stay in GRANT.
//   DONE: api_nc_done=1 for exactly this cycle, then go to IDLE.
//  Selection:
//   - P_RR_EN=0: lowest set index of req_q.
//   - P_RR_EN=1: lowest set index >= ptr; if none, wrap to the lowest set index >= 1.
//   - P_RR_EN=1: after each grant of index i, ptr <= (i==L_NUM_REQ) ? 1 : i+1.
//   - ptr persists across phases and is reset only by rst.
//  Timing: nc_transmit in cycle T with k snapshot bits set gives:
//   - grants in cycles T+1..T+k, back-to-back;
//   - api_nc_done in cycle T+k+1;
//   - for k=0: no grant, api_nc_done in T+1.
//  Snapshot rule:
//   - api_pending changes after T do not affect the current phase.
//   - A bit that rises mid-phase is first eligible at the next nc_transmit.
//   - Grants are issued even if the neuron's pending bit has dropped (a neuron is granted at most once per phase).
//  Overlap: nc_transmit while state!=IDLE is ignored (no re-snapshot) and sets api_err_overlap.
//   - err_clr=1 clears api_err_overlap; if err_clr and an overlap occur in the same cycle, set wins.
//  Arithmetic: api_grant_cnt cannot exceed L_NUM_REQ, so it cannot overflow.
//  Reset mid-phase: outputs drop immediately (asynchronous) with no api_nc_done.
//   - After rst is released, the block waits in IDLE for a new nc_transmit.
//  Invariants: api_granted is one-hot or zero in every cycle; api_vld==|api_granted.
// TESTING
//  1. rst=0 with arbitrary inputs -> all outputs 0; after release, idle with no grants until nc_transmit.
//  2. P_RR_EN=0, pending={3,7,9}, nc_transmit at T -> granted[3]@T+1, [7]@T+2, [9]@T+3; done@T+4; cnt=3.
//  3. pending=0, nc_transmit at T -> api_vld never 1; api_nc_done@T+1; cnt=0.
//  4. pending={4}, bit 5 rises at T+1 -> only 4 granted this phase; next phase grants 5 (pending held).
//  5. P_RR_EN=1: phase1 pending={2,5,8} -> order 2,5,8, ptr=9.
//     Then phase2 pending={2,5,8,10} -> order 10,2,5,8.
//  6. nc_transmit pulsed again at T+2 of a 3-grant phase -> grants unaffected; err_overlap=1 until err_clr.
//     rst=0 at T+2 -> no done pulse.

Source files
------------

// File: rtl/sn_api_sweep_sched.sv
// sn_api_sweep_sched
//   Transmit-phase scheduler for the shared Axon Protocol Interface bus.
//   On nc_transmit it snapshots the pending requests of all non-output
//   neurons. It then grants them one per cycle, so each granted neuron
//   drives api_bus alone, and pulses api_nc_done once the snapshot is empty.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   nc_transmit         transmit-phase start pulse (network controller)
//   api_pending         [L_NUM_REQ:1] spike-pending requests (neuron array)
//   err_clr             clears api_err_overlap
//   api_granted         [L_NUM_REQ:1] one-hot grant, zero when idle
//   api_vld             api_bus valid (|api_granted)
//   api_nc_done         one-cycle end-of-phase pulse
//   api_grant_cnt       grants issued in the current/last phase
//   api_err_overlap     sticky: nc_transmit arrived while a phase was running
module sn_api_sweep_sched #(
  parameter int P_NUM_NEURONS = 100,
  parameter int P_NUM_INPUTS  = 45,
  parameter int P_NUM_OUTPUTS = 3,
  parameter int P_RR_EN       = 0,
  localparam int L_NUM_REQ    = P_NUM_NEURONS - P_NUM_OUTPUTS,
  localparam int L_CNT_BW     = $clog2(L_NUM_REQ + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nc_transmit,
  input  logic [L_NUM_REQ:1]   api_pending,
  input  logic                 err_clr,
  output logic [L_NUM_REQ:1]   api_granted,
  output logic                 api_vld,
  output logic                 api_nc_done,
  output logic [L_CNT_BW-1:0]  api_grant_cnt,
  output logic                 api_err_overlap
);

  // Inputs occupy the low requester indices; there must be hidden neurons too.
  generate
    if (P_NUM_INPUTS < 1 || P_NUM_INPUTS >= L_NUM_REQ) begin : g_bad_cfg
      $error("sn_api_sweep_sched: P_NUM_INPUTS out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t               state, state_nxt;
  logic [L_NUM_REQ:1]   req_q, req_nxt;
  logic [L_CNT_BW-1:0]  ptr, ptr_nxt;
  logic [L_CNT_BW-1:0]  cnt_nxt;

  logic [L_NUM_REQ:1]   ge_mask, masked, pick, sel_oh;
  logic [L_CNT_BW-1:0]  sel_idx;

  // Selection: with rotation, search from ptr upward first and fall back to
  // the whole snapshot (wrap). The lowest set bit is isolated by x & -x.
  always_comb begin
    ge_mask = '0;
    for (int i = 1; i <= L_NUM_REQ; i++)
      ge_mask[i] = (L_CNT_BW'(i) >= ptr);
    masked = req_q & ge_mask;
    pick   = (P_RR_EN != 0 && masked != '0) ? masked : req_q;
    sel_oh = pick & (~pick + L_NUM_REQ'(1));
    sel_idx = '0;
    for (int i = 1; i <= L_NUM_REQ; i++)
      if (sel_oh[i]) sel_idx = L_CNT_BW'(i);
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    ptr_nxt   = ptr;
    cnt_nxt   = api_grant_cnt;
    case (state)
      IDLE: if (nc_transmit) begin
        req_nxt   = api_pending;
        cnt_nxt   = '0;
        state_nxt = (api_pending != '0) ? GRANT : DONE;
      end
      GRANT: begin
        req_nxt = req_q & ~sel_oh;
        cnt_nxt = api_grant_cnt + L_CNT_BW'(1);
        if (P_RR_EN != 0)
          ptr_nxt = (sel_idx == L_CNT_BW'(L_NUM_REQ)) ? L_CNT_BW'(1)
                                                      : sel_idx + L_CNT_BW'(1);
        // Last remaining bit is being granted now.
        if (req_nxt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      req_q           <= '0;
      ptr             <= L_CNT_BW'(1);
      api_grant_cnt   <= '0;
      api_err_overlap <= 1'b0;
    end else begin
      state         <= state_nxt;
      req_q         <= req_nxt;
      ptr           <= ptr_nxt;
      api_grant_cnt <= cnt_nxt;
      // Set has priority over clear.
      if (nc_transmit && state != IDLE) api_err_overlap <= 1'b1;
      else if (err_clr)                 api_err_overlap <= 1'b0;
    end
  end

  // Grant and done decode straight from state, so an asynchronous reset
  // drops them immediately.
  assign api_granted = (state == GRANT) ? sel_oh : '0;
  assign api_vld     = |api_granted;
  assign api_nc_done = (state == DONE);

endmodule

// File: tb/tb_sn_api_sweep_sched.sv
// Directed bench for sn_api_sweep_sched: one fixed-priority and one
// rotating-pointer instance share all stimulus.
module tb_sn_api_sweep_sched;
  localparam int N  = 97;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          nc_transmit;
  logic [N:1]    api_pending;
  logic          err_clr;
  logic [N:1]    g0, g1;
  logic          v0, v1, d0, d1, e0, e1;
  logic [CW-1:0] c0, c1;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sn_api_sweep_sched #(.P_RR_EN(0)) dut0 (
    .clk(clk), .rst(rst), .nc_transmit(nc_transmit), .api_pending(api_pending),
    .err_clr(err_clr), .api_granted(g0), .api_vld(v0), .api_nc_done(d0),
    .api_grant_cnt(c0), .api_err_overlap(e0));

  sn_api_sweep_sched #(.P_RR_EN(1)) dut1 (
    .clk(clk), .rst(rst), .nc_transmit(nc_transmit), .api_pending(api_pending),
    .err_clr(err_clr), .api_granted(g1), .api_vld(v1), .api_nc_done(d1),
    .api_grant_cnt(c1), .api_err_overlap(e1));

  function automatic logic [N:1] oh(input int i);
    logic [N:1] v;
    v = '0;
    if (i >= 1 && i <= N) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with arbitrary inputs
    rst = 1'b0; nc_transmit = 1'b1; api_pending = '1; err_clr = 1'b0;
    #3;
    chk("rst_granted", g0, '0);
    chk("rst_vld", v0, 0);
    chk("rst_done", d0, 0);
    chk("rst_cnt", c0, 0);
    chk("rst_err", e0, 0);
    tick(); tick();
    nc_transmit = 1'b0; api_pending = '0;
    rst = 1'b1;
    tick(); tick(); tick();
    chk("idle_vld", v0, 0);
    chk("idle_done", d0, 0);

    // 2: fixed priority {3,7,9}; pending drops after the snapshot
    api_pending = oh(3) | oh(7) | oh(9); nc_transmit = 1'b1;   // cycle T
    tick(); nc_transmit = 1'b0; api_pending = '0;             // T+1
    chk("fp_g3", g0, oh(3));
    chk("fp_vld", v0, 1);
    chk("fp_cnt0", c0, 0);
    tick(); chk("fp_g7", g0, oh(7));
    chk("fp_cnt1", c0, 1);
    tick(); chk("fp_g9", g0, oh(9));
    chk("fp_done_early", d0, 0);
    tick(); chk("fp_done", d0, 1);                            // T+4
    chk("fp_g_done", g0, '0);
    chk("fp_cnt3", c0, 3);
    tick(); chk("fp_done_once", d0, 0);

    // 3: empty snapshot
    api_pending = '0; nc_transmit = 1'b1;
    tick(); nc_transmit = 1'b0;
    chk("empty_vld", v0, 0);
    chk("empty_done", d0, 1);
    chk("empty_cnt", c0, 0);
    tick(); chk("empty_after", d0, 0);
    chk("empty_vld2", v0, 0);

    // 4: bit 5 rising mid-phase waits for the next phase
    api_pending = oh(4); nc_transmit = 1'b1;
    tick(); nc_transmit = 1'b0; api_pending = oh(4) | oh(5);
    chk("snap_g4", g0, oh(4));
    tick(); chk("snap_done", d0, 1);
    chk("snap_nog5", g0, '0);
    chk("snap_cnt", c0, 1);
    tick(); api_pending = oh(5); nc_transmit = 1'b1;
    tick(); nc_transmit = 1'b0;
    chk("snap_g5", g0, oh(5));
    tick(); chk("snap_done2", d0, 1);
    api_pending = '0;
    tick();

    // 5: rotating pointer after a fresh reset (ptr=1)
    rst = 1'b0; tick(); rst = 1'b1; tick();
    api_pending = oh(2) | oh(5) | oh(8); nc_transmit = 1'b1;
    tick(); nc_transmit = 1'b0;
    chk("rr1_g2", g1, oh(2));
    tick(); chk("rr1_g5", g1, oh(5));
    tick(); chk("rr1_g8", g1, oh(8));
    tick(); chk("rr1_done", d1, 1);
    tick();
    api_pending = oh(2) | oh(5) | oh(8) | oh(10); nc_transmit = 1'b1;
    tick(); nc_transmit = 1'b0;
    chk("rr2_g10", g1, oh(10));
    chk("fp2_g2", g0, oh(2));
    tick(); chk("rr2_g2", g1, oh(2));
    chk("fp2_g5", g0, oh(5));
    tick(); chk("rr2_g5", g1, oh(5));
    tick(); chk("rr2_g8", g1, oh(8));
    chk("fp2_g10", g0, oh(10));
    tick(); chk("rr2_done", d1, 1);
    chk("rr2_cnt", c1, 4);
    api_pending = '0;
    tick();

    // 6a: overlapping nc_transmit is ignored and flagged
    api_pending = oh(3) | oh(7) | oh(9); nc_transmit = 1'b1;  // T
    tick(); nc_transmit = 1'b0; api_pending = oh(1);          // T+1
    chk("ov_g3", g0, oh(3));
    tick(); nc_transmit = 1'b1;                               // T+2
    chk("ov_g7", g0, oh(7));
    chk("ov_err_pre", e0, 0);
    tick(); nc_transmit = 1'b0;                               // T+3
    chk("ov_g9", g0, oh(9));
    chk("ov_err_set", e0, 1);
    tick(); chk("ov_done", d0, 1);                            // T+4
    chk("ov_cnt", c0, 3);
    tick(); chk("ov_idle", v0, 0);
    chk("ov_err_hold", e0, 1);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    chk("ov_err_clr", e0, 0);

    // 6b: reset in the middle of a phase
    api_pending = oh(3) | oh(7) | oh(9); nc_transmit = 1'b1;
    tick(); nc_transmit = 1'b0; api_pending = '0;
    tick(); chk("mr_g7", g0, oh(7));
    rst = 1'b0; #1;
    chk("mr_granted", g0, '0);
    chk("mr_vld", v0, 0);
    chk("mr_cnt", c0, 0);
    tick(); chk("mr_nodone", d0, 0);
    rst = 1'b1;
    tick(); chk("mr_nodone2", d0, 0);
    chk("mr_vld2", v0, 0);
    tick(); chk("mr_idle", v0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
